// File: rtl/config_mac_pkg.sv
// rtl/config_mac_pkg.sv - mode encoding and lane helpers shared by config_mac_scalable and its multiplier
package config_mac_pkg;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'd0,
        MODE_HALF    = 2'd1,
        MODE_QUARTER = 2'd2
    } mode_e;

    localparam int LANES_FULL    = 1;
    localparam int LANES_HALF    = 2;
    localparam int LANES_QUARTER = 4;

    function automatic int lane_count(input mode_e m);
        case (m)
            MODE_HALF:    return LANES_HALF;
            MODE_QUARTER: return LANES_QUARTER;
            default:      return LANES_FULL;
        endcase
    endfunction

    // Raw encoding 3 is reserved and behaves as full precision.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_HALF;
            2'd2:    return MODE_QUARTER;
            default: return MODE_FULL;
        endcase
    endfunction

endpackage

// File: rtl/config_multiplier_scalable.sv
// rtl/config_multiplier_scalable.sv - combinational signed multiplier split into 1, 2 or 4 independent lanes
module config_multiplier_scalable
    import config_mac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  mode_e              mode,
    output logic [2*WIDTH-1:0] product
);

    logic [2:0][2*WIDTH-1:0] prod_m;

    for (genvar m = 0; m < 3; m++) begin : g_mode
        localparam int L  = (m == 0) ? LANES_FULL : ((m == 1) ? LANES_HALF : LANES_QUARTER);
        localparam int OW = WIDTH / L;
        for (genvar i = 0; i < L; i++) begin : g_lane
            logic signed [OW-1:0]   la;
            logic signed [OW-1:0]   lb;
            logic signed [2*OW-1:0] lp;
            assign la = a[i*OW +: OW];
            assign lb = b[i*OW +: OW];
            assign lp = (2*OW)'(la) * (2*OW)'(lb);
            assign prod_m[m][i*2*OW +: 2*OW] = lp;
        end
    end

    always_comb begin
        product = prod_m[0];
        case (mode)
            MODE_HALF:    product = prod_m[1];
            MODE_QUARTER: product = prod_m[2];
            default:      product = prod_m[0];
        endcase
    end

endmodule

// File: rtl/config_mac_scalable.sv
// rtl/config_mac_scalable.sv - pipelined precision-scalable signed MAC with valid/ready streams
// Optional lane saturation and sticky out_sat port: define CONFIG_MAC_SAT_EN.
module config_mac_scalable
    import config_mac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_mode,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_result,
`ifdef CONFIG_MAC_SAT_EN
    output logic                 out_sat,
`endif
    output logic [1:0]           out_mode
);

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e                  state;
    mode_e                   cur_mode;
    mode_e                   beat_mode;
    mode_e                   s1_mode;
    logic                    s1_valid;
    logic                    s1_last;
    logic [2*WIDTH-1:0]      beat_prod;
    logic [2*WIDTH-1:0]      s1_prod;
    logic [ACC_WIDTH-1:0]    acc;
    logic [ACC_WIDTH-1:0]    acc_sum;
    logic [2:0][ACC_WIDTH-1:0] sum_m;
    logic                    stall;
    logic                    accept;

    // Only a finished vector waiting behind an unconsumed result can block the pipe.
    assign stall     = s1_valid && s1_last && out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign beat_mode = (state == IDLE) ? decode_mode(in_mode) : cur_mode;

    config_multiplier_scalable #(.WIDTH(WIDTH)) u_mul (
        .a       (in_a),
        .b       (in_b),
        .mode    (beat_mode),
        .product (beat_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_mode <= MODE_FULL;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!in_last) begin
                        state    <= ACCUM;
                        cur_mode <= beat_mode;
                    end
                end
                ACCUM: begin
                    if (in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_FULL;
            s1_prod  <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_prod <= beat_prod;
                s1_last <= in_last;
                s1_mode <= beat_mode;
            end
        end
    end

`ifdef CONFIG_MAC_SAT_EN
    logic [2:0] ovf_m;
    logic       sat_beat;
    logic       sat_seen;
`endif

    for (genvar m = 0; m < 3; m++) begin : g_acc
        localparam int L  = (m == 0) ? LANES_FULL : ((m == 1) ? LANES_HALF : LANES_QUARTER);
        localparam int LA = ACC_WIDTH / L;
        localparam int LP = 2 * WIDTH / L;
`ifdef CONFIG_MAC_SAT_EN
        logic [L-1:0] lane_ovf;
        assign ovf_m[m] = |lane_ovf;
`endif
        for (genvar i = 0; i < L; i++) begin : g_lane
            logic signed [LP-1:0] prod_l;
            logic signed [LA-1:0] acc_l;
            logic signed [LA-1:0] ext_l;
            logic signed [LA-1:0] sum_l;
            assign prod_l = s1_prod[i*LP +: LP];
            assign acc_l  = acc[i*LA +: LA];
            assign ext_l  = LA'(prod_l);
            assign sum_l  = acc_l + ext_l;
`ifdef CONFIG_MAC_SAT_EN
            // Same-sign operands with a sign flip in the sum means the lane overflowed.
            assign lane_ovf[i] = (acc_l[LA-1] == ext_l[LA-1]) && (sum_l[LA-1] != acc_l[LA-1]);
            assign sum_m[m][i*LA +: LA] = lane_ovf[i] ? {acc_l[LA-1], {(LA-1){~acc_l[LA-1]}}} : sum_l;
`else
            assign sum_m[m][i*LA +: LA] = sum_l;
`endif
        end
    end

    always_comb begin
        acc_sum = sum_m[0];
        case (s1_mode)
            MODE_HALF:    acc_sum = sum_m[1];
            MODE_QUARTER: acc_sum = sum_m[2];
            default:      acc_sum = sum_m[0];
        endcase
    end

`ifdef CONFIG_MAC_SAT_EN
    always_comb begin
        sat_beat = ovf_m[0];
        case (s1_mode)
            MODE_HALF:    sat_beat = ovf_m[1];
            MODE_QUARTER: sat_beat = ovf_m[2];
            default:      sat_beat = ovf_m[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_seen <= 1'b0;
            out_sat  <= 1'b0;
        end else if (s1_valid && !stall) begin
            if (s1_last) begin
                out_sat  <= sat_seen | sat_beat;
                sat_seen <= 1'b0;
            end else begin
                sat_seen <= sat_seen | sat_beat;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_mode   <= 2'd0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (s1_valid && !stall) begin
                if (s1_last) begin
                    out_result <= acc_sum;
                    out_mode   <= s1_mode;
                    out_valid  <= 1'b1;
                    acc        <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: doc/config_mac_scalable.md
Name: config_mac_scalable

Overview:
- Pipelined, signed, precision-scalable multiply-accumulate unit; successor to the combinational config_multiplier_8bit.
- Generalises that block's full/halved precision to full, half and quarter precision at parametrised operand width.
- Accumulates a stream of operand beats per lane and emits one packed result per vector under valid/ready handshakes.
- Sits between the operand feeders and the output writeback in the datapath array.

Parameters:
- WIDTH, 8, operand width; must be divisible by 4.
- ACC_WIDTH, 32, total accumulator width; must be divisible by 4 and be at least 2*WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_a  input  WIDTH  multiplier, packed lanes
- in_b  input  WIDTH  multiplicand, packed lanes
- in_mode  input  2  0 = full (1 lane), 1 = half (2 lanes), 2 = quarter (4 lanes), 3 = treated as full
- in_last  input  1  final beat of the vector
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_result  output  ACC_WIDTH  packed per-lane accumulators
- out_mode  output  2  mode of the vector in out_result

Behaviour:
- Lane count: L = 1, 2 or 4.
- Lane i operand: in_a[i*WIDTH/L +: WIDTH/L], signed.
- Lane i product: 2*WIDTH/L bits, signed.
- Lane i accumulator: ACC_WIDTH/L bits, sign-extended product added, two's complement wrap.
- Lane i result: out_result[i*ACC_WIDTH/L +: ACC_WIDTH/L].
- FSM states: IDLE (no vector open) and ACCUM (vector open).
  - IDLE -> ACCUM on an accepted beat with in_last=0.
  - ACCUM -> IDLE on an accepted beat with in_last=1.
  - An accepted in_last beat in IDLE is a single-beat vector; the state stays IDLE.
- in_mode is latched on the first beat of a vector. in_mode on later beats is ignored until the vector closes.
- Pipeline:
  - S1 registers the lane products, last flag and mode at the acceptance edge.
  - S2 adds the products into the accumulator at the next edge.
  - On a last beat, S2 writes acc+product into the result register, sets out_valid, and clears the accumulator to 0 at the same edge.
- Latency: last beat accepted at edge t -> out_valid high after edge t+1.
- Throughput: one beat per cycle. Back-to-back vectors need no bubble.
- Stall condition: S2 holds a last beat while out_valid=1 and out_ready=0.
  - While stalled, S1 and S2 freeze and in_ready=0.
  - Otherwise in_ready=1, including in the same cycle that out_ready consumes the held result.
- out_valid stays high and out_result/out_mode stay stable until the result is consumed.
- Reset values: out_valid=0, out_result=0, out_mode=0, in_ready=1 (combinational once rst deasserts), accumulators=0, pipeline valid bits=0, FSM=IDLE.
- Reset asserted mid-vector discards all in-flight beats and any held result.

Optional Feature:
- Macro: CONFIG_MAC_SAT_EN.
- Defined: each lane accumulator saturates to [-2^(ACC_WIDTH/L-1), 2^(ACC_WIDTH/L-1)-1] on overflow, and a sticky out_sat output (1 bit) flags any lane that saturated during the vector. out_sat is valid alongside out_result and resets to 0.
- Undefined: accumulators wrap and the out_sat port is absent.

Decomposition:
- Shared package config_mac_pkg holds:
  - the mode enum (MODE_FULL, MODE_HALF, MODE_QUARTER);
  - a lane-count function of the mode;
  - localparams for lane slice widths.
- Sub-module config_multiplier_scalable: combinational WIDTH-bit signed multiplier, split into 1/2/4 independent lanes by mode, producing a packed 2*WIDTH product. Instantiated once, in S1.

Test Plan (WIDTH=8, ACC_WIDTH=32):
- Full mode, single beat a=3, b=3, last=1 -> out_result=0x00000009 after 2 edges, out_mode=0.
- Full mode, beats (-20,-2) then (100,-10, last) -> out_result=0xFFFFFC40 (-960).
- Half mode, a=0x11, b=0x11, last -> 0x00010001. Then a=0xAA, b=0xFF, last -> 0x00060006. Both vectors sent back-to-back with in_ready held high.
- Quarter mode, a=0xFF, b=0x55, last -> each 8-bit lane -1 -> 0xFFFFFFFF. A second beat that changes in_mode to 0 mid-vector must not change the lane split.
- Backpressure: out_ready=0 and two single-beat full-mode vectors (2x3, 4x5) -> first result 6 held, in_ready drops while the second last sits in S2. Raising out_ready -> 6 then 20 delivered in order, no loss.
- Quarter mode, 32 beats of a=0xAA, b=0xAA (lane product 4), rst pulse after beat 5 of a repeat run:
  - Without the macro -> lanes wrap to 0x80.
  - With CONFIG_MAC_SAT_EN -> lanes 0x7F and out_sat=1.
  - The reset run produces no result and the next vector starts from 0.
